video_capture: RTL and testbench

Receive-side counterpart of the CRT video generator: samples the `hdrive`, `vdrive_green` and `video` raster signals on the pixel clock and recovers field, line and pixel position. It packs the 1-bit pixels into bytes and writes them through a framebuffer write port, tagging each field as red or green. It sits between the logic-board video connector and the framebuffer RAM, and lets the design mirror or inspect what the original logic board displays.

---
 rtl/video_capture.sv | 188 ++++++++++++++++++
 tb/tb_video_capture.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// Raster capture: recovers field/line/pixel position from hdrive, vdrive_green and video,
// packs pixels MSB-first into bytes and writes them to a framebuffer byte port.
module video_capture #(
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_SKIP   = 0,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              hdrive,
  input  logic              vdrive_green,
  input  logic              video,
  input  logic              err_clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_field_green,
  output logic              field_start,
  output logic              field_done,
  output logic              err_short,
  output logic              err_vsync
);

  localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);
  localparam int unsigned SKIP_W = (V_SKIP > 0) ? $clog2(V_SKIP + 1) : 1;

  localparam logic [2:0] StWaitField = 3'd0;
  localparam logic [2:0] StVskip     = 3'd1;
  localparam logic [2:0] StLineWait  = 3'd2;
  localparam logic [2:0] StActive    = 3'd3;
  localparam logic [2:0] StFieldDone = 3'd4;

  logic hd_q, hd_q1, vd_q, vd_q1, vid_q;
  logic hd_rise, vd_edge;

  logic [2:0]        state_q, state_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              green_q, green_d;
  logic              fstart_q, fstart_d;
  logic              fdone_q, fdone_d;
  logic              err_short_q, err_short_d;
  logic              err_vsync_q, err_vsync_d;
  logic              line_end;

  // Input pipeline free-runs through reset so a steady vdrive_green never looks like an edge.
  always_ff @(posedge clk_pixel) begin
    hd_q  <= hdrive;
    vd_q  <= vdrive_green;
    vid_q <= video;
    hd_q1 <= hd_q;
    vd_q1 <= vd_q;
  end

  assign hd_rise = hd_q & ~hd_q1;
  assign vd_edge = vd_q ^ vd_q1;

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    line_base_d = line_base_q;
    skip_cnt_d  = skip_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    shift_d     = shift_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    green_d     = green_q;
    fstart_d    = 1'b0;
    fdone_d     = 1'b0;
    err_short_d = err_short_q & ~err_clear;
    err_vsync_d = err_vsync_q & ~err_clear;
    line_end    = 1'b0;

    if (vd_edge) begin
      green_d     = vd_q;
      fstart_d    = 1'b1;
      line_cnt_d  = '0;
      line_base_d = '0;
      skip_cnt_d  = '0;
      state_d     = (V_SKIP == 0) ? StLineWait : StVskip;
      if (state_q == StVskip || state_q == StLineWait || state_q == StActive) begin
        err_vsync_d = 1'b1;
      end
    end else begin
      case (state_q)
        StVskip: begin
          if (hd_rise) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
            if (skip_cnt_q == SKIP_W'(V_SKIP - 1)) state_d = StLineWait;
          end
        end
        StLineWait: begin
          if (hd_rise) begin
            shift_d   = {shift_q[6:0], vid_q};
            pix_cnt_d = PIX_W'(1);
            state_d   = StActive;
          end
        end
        StActive: begin
          if (hd_q) begin
            shift_d   = {shift_q[6:0], vid_q};
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (pix_cnt_q[2:0] == 3'd7) begin
              wr_en_d   = 1'b1;
              wr_data_d = {shift_q[6:0], vid_q};
              wr_addr_d = line_base_q + ADDR_W'(pix_cnt_q >> 3);
            end
            line_end = (pix_cnt_q == PIX_W'(H_ACTIVE - 1));
          end else begin
            // Short line: flush the partial byte left-aligned, then close the line.
            err_short_d = 1'b1;
            if (pix_cnt_q[2:0] != 3'd0) begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_q << (4'd8 - {1'b0, pix_cnt_q[2:0]});
              wr_addr_d = line_base_q + ADDR_W'(pix_cnt_q >> 3);
            end
            line_end = 1'b1;
          end
          if (line_end) begin
            line_base_d = line_base_q + ADDR_W'(H_ACTIVE / 8);
            line_cnt_d  = line_cnt_q + 1'b1;
            if (line_cnt_q == LINE_W'(V_ACTIVE - 1)) begin
              fdone_d = 1'b1;
              state_d = StFieldDone;
            end else begin
              state_d = StLineWait;
            end
          end
        end
        StWaitField, StFieldDone: ;
        default: state_d = StWaitField;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state_q     <= StWaitField;
      line_cnt_q  <= '0;
      line_base_q <= '0;
      skip_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      shift_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      green_q     <= 1'b0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_vsync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      line_base_q <= line_base_d;
      skip_cnt_q  <= skip_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      shift_q     <= shift_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      green_q     <= green_d;
      fstart_q    <= fstart_d;
      fdone_q     <= fdone_d;
      err_short_q <= err_short_d;
      err_vsync_q <= err_vsync_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign wr_field_green = green_q;
  assign field_start    = fstart_q;
  assign field_done     = fdone_q;
  assign err_short      = err_short_q;
  assign err_vsync      = err_vsync_q;

endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture: two instances (V_SKIP 0 and 3) share random raster stimulus and are
// checked against per-line expectations derived from the line timing rules.
module tb_video_capture;

  localparam int H   = 32;
  localparam int V   = 6;
  localparam int SK1 = 3;
  localparam int AW  = 8;
  localparam int KWr = 0;
  localparam int KFs = 1;
  localparam int KFd = 2;

  logic clk_pixel = 1'b0;
  logic rst_n = 1'b0;
  logic hdrive = 1'b0;
  logic vdrive_green = 1'b0;
  logic video = 1'b0;
  logic err_clear = 1'b0;

  logic          wr_en_w   [2];
  logic [AW-1:0] wr_addr_w [2];
  logic [7:0]    wr_data_w [2];
  logic          green_w   [2];
  logic          fs_w      [2];
  logic          fd_w      [2];
  logic          es_w      [2];
  logic          ev_w      [2];

  video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .V_SKIP(0), .ADDR_W(AW)) u_dut0 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .hdrive(hdrive), .vdrive_green(vdrive_green),
    .video(video), .err_clear(err_clear), .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]),
    .wr_data(wr_data_w[0]), .wr_field_green(green_w[0]), .field_start(fs_w[0]),
    .field_done(fd_w[0]), .err_short(es_w[0]), .err_vsync(ev_w[0])
  );

  video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .V_SKIP(SK1), .ADDR_W(AW)) u_dut1 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .hdrive(hdrive), .vdrive_green(vdrive_green),
    .video(video), .err_clear(err_clear), .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]),
    .wr_data(wr_data_w[1]), .wr_field_green(green_w[1]), .field_start(fs_w[1]),
    .field_done(fd_w[1]), .err_short(es_w[1]), .err_vsync(ev_w[1])
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int inst;
    int kind;
    int cyc;
    int addr;
    int data;
    int green;
  } exp_t;
  exp_t exp_q[$];

  // Reference state per instance: 0 waiting, 1 skipping, 2 capturing, 3 field complete
  int   mode_m [2];
  int   skip_m [2];
  int   line_m [2];
  logic green_m[2];
  logic es_m   [2];
  logic ev_m   [2];

  task automatic push(input int i, input int kind, input int c, input int a, input int d,
                      input int g);
    exp_t e;
    e.inst = i; e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.green = g;
    exp_q.push_back(e);
  endtask

  task automatic take(input int i, input int kind, output exp_t e, output bit found);
    found = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k].inst == i && exp_q[k].kind == kind) begin
        e = exp_q[k];
        exp_q.delete(k);
        found = 1'b1;
        break;
      end
    end
  endtask

  function automatic int pack(input logic [31:0] pix, input int b, input int k);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < k; j++) r[7-j] = pix[8*b+j];
    return int'(r);
  endfunction

  task automatic model_field(input int i, input int fs_cyc, input logic new_green);
    push(i, KFs, fs_cyc, 0, 0, 0);
    if (mode_m[i] == 1 || mode_m[i] == 2) ev_m[i] = 1'b1;
    green_m[i] = new_green;
    line_m[i]  = 0;
    skip_m[i]  = (i == 0) ? 0 : SK1;
    mode_m[i]  = (skip_m[i] == 0) ? 2 : 1;
  endtask

  // evt: 0 none, 1 vdrive toggle at pixel t, 2 one-cycle reset at pixel t
  task automatic model_line(input int i, input int n, input int len, input logic [31:0] pix,
                            input int evt, input int t, input logic new_green);
    int eff, base;
    if (mode_m[i] == 1 && evt == 0) begin
      skip_m[i]--;
      if (skip_m[i] == 0) mode_m[i] = 2;
    end else if (mode_m[i] == 2) begin
      base = line_m[i] * (H / 8);
      eff  = (len < H) ? len : H;
      if (evt == 1) eff = t;
      if (evt == 2) eff = t - 1;
      for (int b = 0; 8 * (b + 1) <= eff; b++)
        push(i, KWr, n + 8 * (b + 1), base + b, pack(pix, b, 8), int'(green_m[i]));
      if (evt == 0) begin
        if (len < H) begin
          es_m[i] = 1'b1;
          if (len % 8 != 0)
            push(i, KWr, n + len + 1, base + len / 8, pack(pix, len / 8, len % 8),
                 int'(green_m[i]));
        end
        line_m[i]++;
        if (line_m[i] == V) begin
          push(i, KFd, (len >= H) ? n + H : n + len + 1, 0, 0, 0);
          mode_m[i] = 3;
        end
      end
    end
    if (evt == 1) model_field(i, n + t + 1, new_green);
    if (evt == 2) begin
      mode_m[i] = 0; es_m[i] = 1'b0; ev_m[i] = 1'b0; green_m[i] = 1'b0;
    end
  endtask

  task automatic mon_inst(input int i);
    exp_t e;
    bit   ok;
    if (wr_en_w[i]) begin
      take(i, KWr, e, ok);
      if (!ok) check_eq($sformatf("wr_unexpected%0d", i), int'(wr_en_w[i]), 0);
      else begin
        check_eq($sformatf("wr_cycle%0d", i), cyc, e.cyc);
        check_eq($sformatf("wr_addr%0d", i), int'(wr_addr_w[i]), e.addr);
        check_eq($sformatf("wr_data%0d", i), int'(wr_data_w[i]), e.data);
        check_eq($sformatf("wr_green%0d", i), int'(green_w[i]), e.green);
      end
    end
    if (fs_w[i]) begin
      take(i, KFs, e, ok);
      if (!ok) check_eq($sformatf("fs_unexpected%0d", i), int'(fs_w[i]), 0);
      else check_eq($sformatf("fs_cycle%0d", i), cyc, e.cyc);
    end
    if (fd_w[i]) begin
      take(i, KFd, e, ok);
      if (!ok) check_eq($sformatf("fd_unexpected%0d", i), int'(fd_w[i]), 0);
      else check_eq($sformatf("fd_cycle%0d", i), cyc, e.cyc);
    end
  endtask

  always @(negedge clk_pixel) begin
    for (int i = 0; i < 2; i++) mon_inst(i);
  end

  task automatic check_zero();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_wr_en%0d", i), int'(wr_en_w[i]), 0);
      check_eq($sformatf("rst_wr_addr%0d", i), int'(wr_addr_w[i]), 0);
      check_eq($sformatf("rst_wr_data%0d", i), int'(wr_data_w[i]), 0);
      check_eq($sformatf("rst_green%0d", i), int'(green_w[i]), 0);
      check_eq($sformatf("rst_fs%0d", i), int'(fs_w[i]), 0);
      check_eq($sformatf("rst_fd%0d", i), int'(fd_w[i]), 0);
      check_eq($sformatf("rst_err_short%0d", i), int'(es_w[i]), 0);
      check_eq($sformatf("rst_err_vsync%0d", i), int'(ev_w[i]), 0);
    end
  endtask

  task automatic check_flags(input string where);
    @(negedge clk_pixel);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_err_short%0d", where, i), int'(es_w[i]), int'(es_m[i]));
      check_eq($sformatf("%s_err_vsync%0d", where, i), int'(ev_w[i]), int'(ev_m[i]));
    end
  endtask

  task automatic pulse_err_clear();
    @(negedge clk_pixel);
    err_clear = 1'b1;
    @(negedge clk_pixel);
    err_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      es_m[i] = 1'b0;
      ev_m[i] = 1'b0;
    end
  endtask

  task automatic field_toggle();
    @(negedge clk_pixel);
    for (int i = 0; i < 2; i++) model_field(i, cyc + 2, ~vdrive_green);
    vdrive_green = ~vdrive_green;
    repeat (3) @(negedge clk_pixel);
  endtask

  task automatic drive_line(input int len, input int blank, input logic [31:0] pix,
                            input int evt, input int t);
    for (int i = 0; i < len; i++) begin
      @(negedge clk_pixel);
      if (evt == 2 && i == t + 1) begin
        check_zero();
        rst_n = 1'b1;
      end
      if (i == 0) begin
        for (int k = 0; k < 2; k++) model_line(k, cyc + 1, len, pix, evt, t, ~vdrive_green);
      end
      hdrive = 1'b1;
      video  = (i < H) ? pix[i] : 1'b0;
      if (evt == 1 && i == t) vdrive_green = ~vdrive_green;
      if (evt == 2 && i == t) rst_n = 1'b0;
    end
    for (int i = 0; i < blank; i++) begin
      @(negedge clk_pixel);
      hdrive = 1'b0;
      video  = 1'b0;
    end
  endtask

  task automatic random_line();
    int r, len;
    r   = int'($urandom_range(0, 9));
    len = H;
    if (r == 0) len = int'($urandom_range(1, H - 1));
    if (r == 1) len = H + int'($urandom_range(1, 5));
    drive_line(len, int'($urandom_range(2, 5)), $urandom, 0, 0);
  endtask

  initial begin
    logic [31:0] pix;
    for (int i = 0; i < 2; i++) begin
      mode_m[i] = 0; skip_m[i] = 0; line_m[i] = 0;
      green_m[i] = 1'b0; es_m[i] = 1'b0; ev_m[i] = 1'b0;
    end
    repeat (4) @(negedge clk_pixel);
    check_zero();
    rst_n = 1'b1;
    repeat (3) @(negedge clk_pixel);

    // Checkerboard field, green
    field_toggle();
    for (int l = 0; l < V + SK1 + 1; l++) begin
      pix = '0;
      for (int b = 0; b < H / 8; b++) if (((b + l / 8) % 2) == 1) pix[8*b +: 8] = 8'hFF;
      drive_line(H + 8, 2 + (l % 3), pix, 0, 0);
    end
    check_flags("nominal");

    // Pixel order, then a 13-pixel short line
    field_toggle();
    pix = 32'h0000_0201;
    drive_line(H, 4, pix, 0, 0);
    for (int l = 1; l < V + SK1 + 3; l++) drive_line((l == 5) ? 13 : H, 3, $urandom, 0, 0);
    check_flags("short");
    pulse_err_clear();
    check_flags("clear1");

    // Field edge mid-line, then coincident with an hdrive rise
    field_toggle();
    drive_line(H, 3, $urandom, 0, 0);
    drive_line(H, 3, $urandom, 0, 0);
    drive_line(H, 3, $urandom, 1, 20);
    drive_line(H, 3, $urandom, 0, 0);
    drive_line(H, 3, $urandom, 1, 0);
    for (int l = 0; l < V + SK1 + 1; l++) drive_line(H, 2, $urandom, 0, 0);
    check_flags("vsync");
    pulse_err_clear();
    check_flags("clear2");

    // Randomised fields
    for (int f = 0; f < 6; f++) begin
      field_toggle();
      for (int l = 0; l < V + SK1 + 3; l++) begin
        if (f == 2 && l == 1) drive_line(H, 3, $urandom, 1, int'($urandom_range(0, H - 1)));
        else random_line();
      end
      check_flags("rand");
      pulse_err_clear();
      check_flags("rand_clear");
    end

    // Reset mid-line: no writes until the next field edge
    field_toggle();
    drive_line(H, 3, $urandom, 0, 0);
    drive_line(H, 3, $urandom, 0, 0);
    drive_line(H, 3, $urandom, 2, 20);
    for (int l = 0; l < 3; l++) drive_line(H, 3, $urandom, 0, 0);
    check_flags("after_reset");
    field_toggle();
    for (int l = 0; l < V + SK1 + 1; l++) random_line();
    check_flags("final");

    repeat (20) @(negedge clk_pixel);
    check_eq("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
